// File: rtl/fwd_packet_fifo_if.sv
// Stream bundle for fwd_packet_fifo: s_* carries beats from the filter forwarder, m_* feeds the sink.
interface fwd_packet_fifo_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] s_TDATA;
  logic                  s_TVALID;
  logic                  s_TLAST;
  logic                  s_TREADY;
  logic [DATA_WIDTH-1:0] m_TDATA;
  logic                  m_TVALID;
  logic                  m_TLAST;
  logic                  m_TREADY;

  // FIFO side
  modport slave (
    input  s_TDATA, s_TVALID, s_TLAST, m_TREADY,
    output s_TREADY, m_TDATA, m_TVALID, m_TLAST
  );

  // Forwarder/sink side
  modport master (
    output s_TDATA, s_TVALID, s_TLAST, m_TREADY,
    input  s_TREADY, m_TDATA, m_TVALID, m_TLAST
  );
endinterface

// File: rtl/fwd_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: only complete packets reach the sink; packets that overflow are dropped whole and counted.
// Optional macro FWD_FIFO_DROP_CLR_EN: stat_rd_strobe clears num_dropped on the next edge.
module fwd_packet_fifo #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  fwd_packet_fifo_if.slave          axis,
  input  logic                      stat_rd_strobe,
  output logic [DROP_CNT_WIDTH-1:0] num_dropped,
  output logic [ADDR_WIDTH:0]       pkts_queued
);
  localparam int unsigned PTR_W   = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_e;

  wr_state_e                 state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          pkts_q, pkts_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      m_valid_q, m_valid_d;
  logic                      m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0]     m_data_q, m_data_d;
  logic [ENTRY_W-1:0]        mem_q [DEPTH];

  logic                      full_c;
  logic                      mem_we_c;
  logic                      commit_c;
  logic                      drop_c;
  logic                      rd_en_c;
  logic                      last_hs_c;
  logic                      clr_c;
  logic [ENTRY_W-1:0]        rd_entry_c;

  // Uncommitted beats count against space, so a packet that cannot finish is caught here.
  assign full_c     = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
  assign rd_entry_c = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

`ifdef FWD_FIFO_DROP_CLR_EN
  assign clr_c = stat_rd_strobe;
`else
  logic unused_strobe;
  assign unused_strobe = stat_rd_strobe;
  assign clr_c         = 1'b0;
`endif

  // Write side: store beats, commit on TLAST, rewind and drop the packet on overflow.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we_c     = 1'b0;
    commit_c     = 1'b0;
    drop_c       = 1'b0;
    if (axis.s_TVALID) begin
      case (state_q)
        ST_ACCEPT: begin
          if (!full_c) begin
            mem_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (axis.s_TLAST) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              commit_c     = 1'b1;
            end
          end else begin
            wr_ptr_d = commit_ptr_q;
            drop_c   = 1'b1;
            if (!axis.s_TLAST) state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (axis.s_TLAST) state_d = ST_ACCEPT;
        end
        default: state_d = ST_ACCEPT;
      endcase
    end
  end

  // Read side: the output register doubles as the storage read register.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    rd_en_c   = (rd_ptr_q != commit_ptr_q) && (!m_valid_q || axis.m_TREADY);
    last_hs_c = m_valid_q && m_last_q && axis.m_TREADY;
    if (rd_en_c) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      m_valid_d = 1'b1;
      m_data_d  = rd_entry_c[DATA_WIDTH-1:0];
      m_last_d  = rd_entry_c[DATA_WIDTH];
    end else if (axis.m_TREADY) begin
      m_valid_d = 1'b0;
    end
  end

  // Packet and drop counters; a clear coinciding with a drop leaves exactly that drop counted.
  always_comb begin
    pkts_d     = pkts_q + PTR_W'(commit_c) - PTR_W'(last_hs_c);
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    if (clr_c) drop_cnt_d = DROP_CNT_WIDTH'(drop_c);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= ST_ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkts_q       <= '0;
      drop_cnt_q   <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkts_q       <= pkts_d;
      drop_cnt_q   <= drop_cnt_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
    end
  end

  // Storage array is not reset; pointers alone define what is valid.
  always_ff @(posedge axi_aclk) begin
    if (mem_we_c) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {axis.s_TLAST, axis.s_TDATA};
  end

  assign axis.s_TREADY = axi_aresetn;
  assign axis.m_TVALID = m_valid_q;
  assign axis.m_TLAST  = m_last_q;
  assign axis.m_TDATA  = m_data_q;
  assign num_dropped   = drop_cnt_q;
  assign pkts_queued   = pkts_q;
endmodule

// File: tb/tb_fwd_packet_fifo.sv
// Self-checking bench for fwd_packet_fifo with a queue-based packet model; 16-entry buffer, 3-bit drop counter.
module tb_fwd_packet_fifo;
  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 4;
  localparam int unsigned DCW   = 3;
  localparam int unsigned PQ_W  = AW + 1;
  localparam int          DEPTH = 16;
  localparam int          DROP_MAX = 7;
`ifdef FWD_FIFO_DROP_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic           strobe = 1'b0;
  logic [DCW-1:0] num_dropped;
  logic [AW:0]    pkts_queued;

  fwd_packet_fifo_if #(.DATA_WIDTH(DW)) axis ();

  fwd_packet_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DROP_CNT_WIDTH(DCW)) dut (
    .axi_aclk      (clk),
    .axi_aresetn   (rst_n),
    .axis          (axis),
    .stat_rd_strobe(strobe),
    .num_dropped   (num_dropped),
    .pkts_queued   (pkts_queued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW:0] cq[$];    // committed beats still in the buffer {last,data}
  logic [DW:0] pq[$];    // beats of the packet currently being written
  logic [DW:0] outq[$];  // beats handed to the sink
  int          outcyc[$];
  logic          mo_valid, mo_last;
  logic [DW-1:0] mo_data;
  int            mo_pkts, mo_drops;
  bit            mo_dropping;
  bit            saw_valid;

  task automatic model_reset();
    cq.delete(); pq.delete();
    mo_valid = 1'b0; mo_last = 1'b0; mo_data = '0;
    mo_pkts = 0; mo_drops = 0; mo_dropping = 1'b0;
  endtask

  // Packet-level model of one clock edge, using the values present just before it.
  task automatic model_step();
    bit full, rd, last_hs, commit, drop;
    logic [DW:0] b;
    full    = (cq.size() + pq.size()) == DEPTH;
    rd      = (cq.size() != 0) && (!mo_valid || axis.m_TREADY);
    last_hs = mo_valid && mo_last && axis.m_TREADY;
    commit  = 1'b0;
    drop    = 1'b0;
    if (rd) begin
      b = cq.pop_front();
      mo_valid = 1'b1; mo_last = b[DW]; mo_data = b[DW-1:0];
    end else if (axis.m_TREADY) begin
      mo_valid = 1'b0;
    end
    if (axis.s_TVALID) begin
      if (mo_dropping) mo_dropping = !axis.s_TLAST;
      else if (!full) begin
        pq.push_back({axis.s_TLAST, axis.s_TDATA});
        if (axis.s_TLAST) begin
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
          commit = 1'b1;
        end
      end else begin
        pq.delete();
        drop = 1'b1;
        mo_dropping = !axis.s_TLAST;
      end
    end
    mo_pkts = mo_pkts + int'(commit) - int'(last_hs);
    if (strobe && CLR_EN) mo_drops = int'(drop);
    else if (drop && mo_drops < DROP_MAX) mo_drops++;
  endtask

  task automatic tick();
    if (axis.m_TVALID && axis.m_TREADY) begin
      outq.push_back({axis.m_TLAST, axis.m_TDATA});
      outcyc.push_back(cyc);
    end
    if (axis.m_TVALID) saw_valid = 1'b1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    axis.s_TVALID = 1'b0;
    axis.s_TLAST  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      axis.s_TVALID = 1'b1;
      axis.s_TDATA  = base + DW'(i);
      axis.s_TLAST  = (i == len - 1);
      tick();
    end
    idle();
  endtask

  task automatic drain(input int max_cycles);
    axis.m_TREADY = 1'b1;
    for (int i = 0; i < max_cycles && (pkts_queued != 0 || axis.m_TVALID); i++) tick();
  endtask

  task automatic do_reset();
    idle();
    axis.s_TDATA = '0; axis.m_TREADY = 1'b0; strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    outq.delete(); outcyc.delete(); saw_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    axis.s_TDATA = '0; axis.m_TREADY = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({axis.m_TVALID, axis.m_TLAST, axis.m_TDATA, pkts_queued, num_dropped, axis.s_TREADY} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h pq=%0d nd=%0d rdy=%b want all 0",
               axis.m_TVALID, axis.m_TLAST, axis.m_TDATA, pkts_queued, num_dropped, axis.s_TREADY);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (axis.s_TREADY !== 1'b1) begin
      failures++; $display("FAIL reset_sready_after got %b want 1", axis.s_TREADY);
    end
    @(negedge clk);
  endtask

  task automatic test_single_packet();
    logic [DW:0] exp[$];
    do_reset();
    send_pkt(3, DW'(64'hA1));
    checks++;
    if (axis.m_TVALID !== 1'b0) begin
      failures++; $display("FAIL single_valid_at_last got %b want 0", axis.m_TVALID);
    end
    tick();
    checks++;
    if ({axis.m_TVALID, axis.m_TLAST, axis.m_TDATA, pkts_queued} !== {1'b1, 1'b0, DW'(64'hA1), PQ_W'(1)}) begin
      failures++;
      $display("FAIL single_first_beat got v=%b l=%b d=%h pq=%0d want v=1 l=0 d=a1 pq=1",
               axis.m_TVALID, axis.m_TLAST, axis.m_TDATA, pkts_queued);
    end
    drain(10);
    exp.push_back({1'b0, DW'(64'hA1)});
    exp.push_back({1'b0, DW'(64'hA2)});
    exp.push_back({1'b1, DW'(64'hA3)});
    checks++;
    if (outq.size() != 3 || pkts_queued !== '0 || axis.m_TVALID !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got beats=%0d pq=%0d v=%b want beats=3 pq=0 v=0", outq.size(), pkts_queued, axis.m_TVALID);
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (outq[i] !== exp[i]) begin
          failures++; $display("FAIL single_beat%0d got %h want %h", i, outq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW:0] want;
    do_reset();
    axis.m_TREADY = 1'b1;
    send_pkt(8, DW'(64'h100));
    send_pkt(8, DW'(64'h200));
    for (int i = 0; i < 40 && outq.size() < 16; i++) tick();
    checks++;
    if (outq.size() != 16 || num_dropped !== '0) begin
      failures++;
      $display("FAIL b2b_count got beats=%0d nd=%0d want beats=16 nd=0", outq.size(), num_dropped);
    end else begin
      for (int i = 0; i < 16; i++) begin
        want = {(i == 7 || i == 15), (i < 8) ? DW'(64'h100 + i) : DW'(64'h200 + i - 8)};
        checks++;
        if (outq[i] !== want || outcyc[i] != outcyc[0] + i) begin
          failures++;
          $display("FAIL b2b_beat%0d got %h at +%0d want %h at +%0d", i, outq[i], outcyc[i] - outcyc[0], want, i);
        end
      end
    end
  endtask

  task automatic test_overflow_drop();
    do_reset();
    send_pkt(10, DW'(64'h300));
    // The first P1 beat moves into the output register, so P2's eighth beat is the first to see a full buffer.
    for (int i = 0; i < 8; i++) begin
      axis.s_TVALID = 1'b1;
      axis.s_TDATA  = DW'(64'h400 + i);
      axis.s_TLAST  = (i == 7);
      tick();
      if (i == 6 || i == 7) begin
        checks++;
        if (num_dropped !== DCW'(i - 6)) begin
          failures++; $display("FAIL ovf_drop_beat%0d got %0d want %0d", i + 1, num_dropped, i - 6);
        end
      end
    end
    idle();
    checks++;
    if (pkts_queued !== PQ_W'(1)) begin
      failures++; $display("FAIL ovf_pkts got %0d want 1", pkts_queued);
    end
    drain(40);
    checks++;
    if (outq.size() != 10) begin
      failures++; $display("FAIL ovf_p1_count got %0d want 10", outq.size());
    end else begin
      foreach (outq[i]) begin
        checks++;
        if (outq[i] !== {(i == 9), DW'(64'h300 + i)}) begin
          failures++; $display("FAIL ovf_p1_beat%0d got %h want %h", i, outq[i], {(i == 9), DW'(64'h300 + i)});
        end
      end
    end
    outq.delete();
    send_pkt(4, DW'(64'h500));
    drain(20);
    checks++;
    if (outq.size() != 4 || num_dropped !== DCW'(1)) begin
      failures++; $display("FAIL ovf_p3_count got beats=%0d nd=%0d want beats=4 nd=1", outq.size(), num_dropped);
    end else begin
      foreach (outq[i]) begin
        checks++;
        if (outq[i] !== {(i == 3), DW'(64'h500 + i)}) begin
          failures++; $display("FAIL ovf_p3_beat%0d got %h want %h", i, outq[i], {(i == 3), DW'(64'h500 + i)});
        end
      end
    end
  endtask

  task automatic test_oversize();
    do_reset();
    axis.m_TREADY = 1'b1;
    send_pkt(20, DW'(64'h600));
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (saw_valid || num_dropped !== DCW'(1) || pkts_queued !== '0) begin
      failures++;
      $display("FAIL oversize_drop got saw_valid=%b nd=%0d pq=%0d want saw_valid=0 nd=1 pq=0", saw_valid, num_dropped, pkts_queued);
    end
    send_pkt(2, DW'(64'h680));
    drain(10);
    checks++;
    if (outq.size() != 2 || outq[0] !== {1'b0, DW'(64'h680)} || outq[1] !== {1'b1, DW'(64'h681)}) begin
      failures++; $display("FAIL oversize_follow got beats=%0d first=%h want beats=2 first=%h", outq.size(), outq.size() > 0 ? outq[0] : '0, {1'b0, DW'(64'h680)});
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send_pkt(3, DW'(64'h700));
    send_pkt(15, DW'(64'h710));
    checks++;
    if (num_dropped !== DCW'(1) || pkts_queued !== PQ_W'(1)) begin
      failures++; $display("FAIL rstmid_pre got nd=%0d pq=%0d want nd=1 pq=1", num_dropped, pkts_queued);
    end
    for (int i = 0; i < 5; i++) begin
      axis.s_TVALID = 1'b1; axis.s_TDATA = DW'(64'h720 + i); axis.s_TLAST = 1'b0;
      tick();
    end
    idle();
    checks++;
    if (axis.m_TVALID !== 1'b1) begin
      failures++; $display("FAIL rstmid_valid_before got %b want 1", axis.m_TVALID);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({axis.m_TVALID, axis.m_TLAST, axis.m_TDATA, pkts_queued, num_dropped, axis.s_TREADY} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got v=%b l=%b d=%h pq=%0d nd=%0d rdy=%b want all 0",
               axis.m_TVALID, axis.m_TLAST, axis.m_TDATA, pkts_queued, num_dropped, axis.s_TREADY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    outq.delete();
    send_pkt(3, DW'(64'h730));
    drain(10);
    checks++;
    if (outq.size() != 3) begin
      failures++; $display("FAIL rstmid_after_count got %0d want 3", outq.size());
    end else begin
      foreach (outq[i]) begin
        checks++;
        if (outq[i] !== {(i == 2), DW'(64'h730 + i)}) begin
          failures++; $display("FAIL rstmid_after_beat%0d got %h want %h", i, outq[i], {(i == 2), DW'(64'h730 + i)});
        end
      end
    end
  endtask

  task automatic test_drop_clear();
    int want;
    do_reset();
    send_pkt(16, DW'(64'h800));
    tick();
    send_pkt(1, DW'(64'h8FF));
    checks++;
    if (pkts_queued !== PQ_W'(2)) begin
      failures++; $display("FAIL clr_fill_pkts got %0d want 2", pkts_queued);
    end
    for (int i = 0; i < 3; i++) send_pkt(1, DW'(64'h900 + i));
    checks++;
    if (num_dropped !== DCW'(3)) begin
      failures++; $display("FAIL clr_three_drops got %0d want 3", num_dropped);
    end
    strobe = 1'b1;
    send_pkt(1, DW'(64'h9A0));
    strobe = 1'b0;
    want = CLR_EN ? 1 : 4;
    checks++;
    if (num_dropped !== DCW'(want)) begin
      failures++; $display("FAIL clr_strobe_with_drop got %0d want %0d", num_dropped, want);
    end
    for (int i = 0; i < 8; i++) send_pkt(1, DW'(64'hA00 + i));
    checks++;
    if (num_dropped !== DCW'(DROP_MAX) || pkts_queued !== PQ_W'(2)) begin
      failures++; $display("FAIL clr_saturate got nd=%0d pq=%0d want nd=%0d pq=2", num_dropped, pkts_queued, DROP_MAX);
    end
    drain(60);
    checks++;
    if (outq.size() != 17 || outq[15] !== {1'b1, DW'(64'h80F)} || outq[16] !== {1'b1, DW'(64'h8FF)}) begin
      failures++; $display("FAIL clr_drain got beats=%0d want 17 ending 80f/8ff", outq.size());
    end
  endtask

  task automatic test_random();
    int rem = 0;
    do_reset();
    for (int c = 0; c < 3200; c++) begin
      if (c < 3000) begin
        if (rem == 0 && $urandom_range(0, 3) != 0) rem = $urandom_range(1, 20);
        if (rem != 0 && $urandom_range(0, 9) < 8) begin
          axis.s_TVALID = 1'b1;
          axis.s_TDATA  = DW'({$urandom, $urandom});
          rem--;
          axis.s_TLAST  = (rem == 0);
        end else begin
          axis.s_TVALID = 1'b0;
          axis.s_TLAST  = 1'($urandom_range(0, 1));
        end
        axis.m_TREADY = ((c / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
        strobe = ($urandom_range(0, 63) == 0);
      end else begin
        idle();
        axis.m_TREADY = 1'b1;
        strobe = 1'b0;
      end
      tick();
      checks++;
      if ({axis.m_TVALID, axis.m_TLAST, axis.m_TDATA} !== {mo_valid, mo_last, mo_data} ||
          pkts_queued !== PQ_W'(mo_pkts) || num_dropped !== DCW'(mo_drops) || axis.s_TREADY !== 1'b1) begin
        failures++;
        if (failures < 20)
          $display("FAIL random_cycle%0d got v=%b l=%b d=%h pq=%0d nd=%0d want v=%b l=%b d=%h pq=%0d nd=%0d",
                   c, axis.m_TVALID, axis.m_TLAST, axis.m_TDATA, pkts_queued, num_dropped,
                   mo_valid, mo_last, mo_data, mo_pkts, mo_drops);
      end
    end
    checks++;
    if (pkts_queued !== '0 || axis.m_TVALID !== 1'b0) begin
      failures++; $display("FAIL random_drained got pq=%0d v=%b want pq=0 v=0", pkts_queued, axis.m_TVALID);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_overflow_drop();
    test_oversize();
    test_reset_mid_packet();
    test_drop_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
